// File: rtl/perf_monitor_pkg.sv
// perf_monitor shared definitions: register map, counter width, CTRL bits, counter indices.
package perf_pkg;

  localparam int PERF_CNT_WIDTH = 32;
  localparam int PERF_NUM_CNT   = 4;
  localparam logic [PERF_CNT_WIDTH-1:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

  localparam logic [3:0] PERF_CYC_LO = 4'd0;
  localparam logic [3:0] PERF_CYC_HI = 4'd1;
  localparam logic [3:0] PERF_INS_LO = 4'd2;
  localparam logic [3:0] PERF_INS_HI = 4'd3;
  localparam logic [3:0] PERF_RD_LO  = 4'd4;
  localparam logic [3:0] PERF_RD_HI  = 4'd5;
  localparam logic [3:0] PERF_WR_LO  = 4'd6;
  localparam logic [3:0] PERF_WR_HI  = 4'd7;
  localparam logic [3:0] PERF_CTRL   = 4'd8;
  localparam logic [3:0] PERF_STATUS = 4'd9;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int CTRL_FROZEN_BIT = 2;

  typedef enum logic [1:0] {
    CNT_CYC = 2'd0,
    CNT_INS = 2'd1,
    CNT_RD  = 2'd2,
    CNT_WR  = 2'd3
  } perf_cnt_e;

  // Counter words occupy offsets 0..7 as lo/hi pairs.
  function automatic logic is_cnt_lo(input logic [3:0] off);
    return (off[3] == 1'b0) && (off[0] == 1'b0);
  endfunction

endpackage

// File: rtl/perf_monitor_if.sv
// CPU bus signals snooped by the performance monitor (data bus stays a plain inout).
interface perf_monitor_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int PC_WIDTH   = 10
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  read;
  logic                  write;
  logic [PC_WIDTH-1:0]   pc;
  logic                  halted;

  modport master (output bus_addr, read, write, pc, halted);
  modport slave  (input  bus_addr, read, write, pc, halted);
endinterface

// File: rtl/perf_monitor_counter.sv
// One saturating 32-bit event counter with a sticky overflow flag.
module perf_counter
  import perf_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      inc_i,
  input  logic                      ovf_clr_i,
  output logic [PERF_CNT_WIDTH-1:0] cnt_o,
  output logic                      ovf_o,
  output logic                      ovf_d_o
);
  logic [PERF_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;

  // Clear wins; a fresh overflow beats a same-cycle W1C of the flag.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = {PERF_CNT_WIDTH{1'b0}};
      ovf_d = 1'b0;
    end else if (inc_i && (cnt_q == PERF_CNT_MAX)) begin
      ovf_d = 1'b1;
    end else if (inc_i) begin
      cnt_d = cnt_q + PERF_CNT_WIDTH'(1'b1);
      ovf_d = ovf_q & ~ovf_clr_i;
    end else begin
      ovf_d = ovf_q & ~ovf_clr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {PERF_CNT_WIDTH{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;
  assign ovf_d_o = ovf_d;

endmodule

// File: rtl/perf_monitor.sv
// Bus-snooping performance monitor with a 16-word register window.
// Define PERF_SNAPSHOT_EN to make a lo-then-hi read pair return a coherent 32-bit value.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 20'hFF000
) (
  input  logic                  clk,
  input  logic                  reset,
  perf_monitor_if.slave         bus,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  overflow
);
  logic [ADDR_WIDTH-1:0]     rel_s;
  logic                      hit_s;
  logic [3:0]                off_s;
  logic                      win_rd_s, win_wr_s, ctrl_wr_s, status_wr_s, clr_s, active_s;
  logic [PERF_NUM_CNT-1:0]   inc_s, ovf_s, ovf_d_s, ovf_clr_s;
  logic [PERF_CNT_WIDTH-1:0] cnt_s [PERF_NUM_CNT];
  logic [DATA_WIDTH-1:0]     hi_s  [PERF_NUM_CNT];
  logic [DATA_WIDTH-1:0]     rd_data_s;

  logic                en_q, en_d;
  logic                frozen_q, frozen_d;
  logic                first_q, first_d;
  logic [PC_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic                overflow_q, overflow_d;

  assign rel_s = bus.bus_addr - START_ADDRESS;
  assign off_s = rel_s[3:0];

  // Window decode and per-counter event qualification.
  always_comb begin
    hit_s       = (bus.bus_addr >= START_ADDRESS) && (rel_s < ADDR_WIDTH'(5'd16));
    win_rd_s    = bus.read  & hit_s;
    win_wr_s    = bus.write & hit_s;
    ctrl_wr_s   = win_wr_s & (off_s == PERF_CTRL);
    status_wr_s = win_wr_s & (off_s == PERF_STATUS);
    clr_s       = ctrl_wr_s & bus_data[CTRL_CLR_BIT];
    active_s    = en_q & ~frozen_q & ~bus.halted;
    inc_s[CNT_CYC] = active_s;
    inc_s[CNT_INS] = active_s & (first_q | (bus.pc != prev_pc_q));
    inc_s[CNT_RD]  = active_s & bus.read  & ~hit_s;
    inc_s[CNT_WR]  = active_s & bus.write & ~hit_s;
    ovf_clr_s      = {PERF_NUM_CNT{status_wr_s}} & bus_data[PERF_NUM_CNT-1:0];
  end

  for (genvar i = 0; i < PERF_NUM_CNT; i++) begin : g_cnt
    perf_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (clr_s),
      .inc_i     (inc_s[i]),
      .ovf_clr_i (ovf_clr_s[i]),
      .cnt_o     (cnt_s[i]),
      .ovf_o     (ovf_s[i]),
      .ovf_d_o   (ovf_d_s[i])
    );
  end

  // Control state next values; overflow tracks the flags' next state so it lands with them.
  always_comb begin
    en_d       = ctrl_wr_s ? bus_data[CTRL_EN_BIT] : en_q;
    frozen_d   = clr_s ? 1'b0 : (frozen_q | bus.halted);
    first_d    = clr_s ? 1'b1 : (active_s ? 1'b0 : first_q);
    prev_pc_d  = bus.pc;
    overflow_d = |ovf_d_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b1;
      frozen_q   <= 1'b0;
      first_q    <= 1'b1;
      prev_pc_q  <= {PC_WIDTH{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      frozen_q   <= frozen_d;
      first_q    <= first_d;
      prev_pc_q  <= prev_pc_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [DATA_WIDTH-1:0] shadow_q [PERF_NUM_CNT];
  logic [DATA_WIDTH-1:0] shadow_d [PERF_NUM_CNT];

  // A lo-word read captures the matching hi word as it stands at that edge.
  always_comb begin
    shadow_d = shadow_q;
    if (win_rd_s && is_cnt_lo(off_s)) begin
      shadow_d[off_s[2:1]] = cnt_s[off_s[2:1]][PERF_CNT_WIDTH-1:16];
    end else begin
      shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PERF_NUM_CNT; i++) shadow_q[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign hi_s = shadow_q;
`else
  // Hi words come straight from the live counters.
  always_comb begin
    for (int i = 0; i < PERF_NUM_CNT; i++) hi_s[i] = cnt_s[i][PERF_CNT_WIDTH-1:16];
  end
`endif

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    case (off_s)
      PERF_CYC_LO, PERF_INS_LO, PERF_RD_LO, PERF_WR_LO: rd_data_s = cnt_s[off_s[2:1]][15:0];
      PERF_CYC_HI, PERF_INS_HI, PERF_RD_HI, PERF_WR_HI: rd_data_s = hi_s[off_s[2:1]];
      PERF_CTRL:   rd_data_s = DATA_WIDTH'({frozen_q, 1'b0, en_q});
      PERF_STATUS: rd_data_s = {{(DATA_WIDTH-PERF_NUM_CNT){1'b0}}, ovf_s};
      default:     rd_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign bus_data = win_rd_s ? rd_data_s : {DATA_WIDTH{1'bz}};
  assign overflow = overflow_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed plus randomized bench for perf_monitor against a rule-level reference model.
module tb_perf_monitor;
  localparam logic [19:0] BASE = 20'hFF000;
`ifdef PERF_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic overflow;
  logic drv_en;
  logic [15:0] drv_val;
  wire  [15:0] bus_data;

  always #5 clk = ~clk;

  perf_monitor_if #(.ADDR_WIDTH(20), .PC_WIDTH(10)) bus_if ();
  assign bus_data = drv_en ? drv_val : 16'hzzzz;

  perf_monitor #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .PC_WIDTH(10), .START_ADDRESS(BASE)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .bus_data (bus_data),
    .overflow (overflow)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain counts and flags updated from the behavioural rules.
  longint unsigned m_cnt [4];
  logic [3:0]  m_ovf;
  logic [15:0] m_shadow [4];
  bit          m_en, m_frozen, m_first, m_overflow, m_valid;
  logic [9:0]  m_prev_pc;
  logic [15:0] last_rd;
  logic [9:0]  cur_pc;
  bit          cur_halt;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [19:0] a);
    return ({12'd0, a} >= 32'h000F_F000) && ({12'd0, a} < 32'h000F_F010);
  endfunction

  function automatic logic [15:0] m_read(input int off);
    longint unsigned v;
    if (off < 8) begin
      v = m_cnt[off / 2];
      if (off % 2 == 0) return v[15:0];
      return SNAP ? m_shadow[off / 2] : v[31:16];
    end
    if (off == 8) return {13'd0, m_frozen, 1'b0, m_en};
    if (off == 9) return {12'd0, m_ovf};
    return 16'h0000;
  endfunction

  task automatic model_edge(input logic [19:0] addr, input bit rd, input bit wr,
                            input logic [15:0] wd, input logic [9:0] pcv, input bit hlt, input bit rst);
    bit hit, active, clr;
    bit inc [4];
    int off;
    longint unsigned hv;
    hit = in_win(addr);
    off = hit ? int'(addr - BASE) : -1;
    if (rst) begin
      foreach (m_cnt[i]) begin m_cnt[i] = 0; m_shadow[i] = 16'h0000; end
      m_ovf = 4'h0; m_en = 1'b1; m_frozen = 1'b0; m_first = 1'b1;
      m_prev_pc = 10'd0; m_overflow = 1'b0; m_valid = 1'b1;
      return;
    end
    active = m_en && !m_frozen && !hlt;
    clr = wr && off == 8 && wd[1];
    if (rd && off >= 0 && off < 8 && off % 2 == 0) begin
      hv = m_cnt[off / 2];
      m_shadow[off / 2] = hv[31:16];
    end
    if (clr) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = 4'h0; m_first = 1'b1; m_frozen = 1'b0;
    end else begin
      if (wr && off == 9) m_ovf = m_ovf & ~wd[3:0];
      inc[0] = active;
      inc[1] = active && (m_first || pcv != m_prev_pc);
      inc[2] = active && rd && !hit;
      inc[3] = active && wr && !hit;
      for (int i = 0; i < 4; i++) begin
        if (inc[i]) begin
          if (m_cnt[i] == 64'h0000_0000_FFFF_FFFF) m_ovf[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (active) m_first = 1'b0;
      if (hlt) m_frozen = 1'b1;
    end
    if (wr && off == 8) m_en = wd[0];
    m_prev_pc = pcv;
    m_overflow = |m_ovf;
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic cyc(input logic [19:0] addr, input bit rd, input bit wr,
                     input logic [15:0] wd, input logic [9:0] pcv, input bit hlt, input bit rst);
    bus_if.bus_addr = addr; bus_if.read = rd; bus_if.write = wr;
    bus_if.pc = pcv; bus_if.halted = hlt; reset = rst;
    drv_en = wr; drv_val = wd;
    #1;
    last_rd = bus_data;
    if (!rst && m_valid) begin
      if (rd && in_win(addr)) check("win_read", bus_data, m_read(int'(addr - BASE)));
      else if (!wr) check("bus_z", bus_data, 16'hzzzz);
    end
    @(posedge clk);
    model_edge(addr, rd, wr, wd, pcv, hlt, rst);
    @(negedge clk);
    drv_en = 1'b0;
    if (m_valid) check("overflow", {15'd0, overflow}, {15'd0, m_overflow});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(20'h00000, 1'b0, 1'b0, 16'h0000, cur_pc, cur_halt, 1'b0);
  endtask

  task automatic rdc(input logic [3:0] off, input logic [15:0] exp, input string tag);
    cyc(BASE + {16'd0, off}, 1'b1, 1'b0, 16'h0000, cur_pc, cur_halt, 1'b0);
    check(tag, last_rd, exp);
  endtask

  task automatic wrc(input logic [3:0] off, input logic [15:0] data);
    cyc(BASE + {16'd0, off}, 1'b0, 1'b1, data, cur_pc, cur_halt, 1'b0);
  endtask

  function automatic logic [19:0] rand_outside();
    case ($urandom_range(0, 3))
      0: return BASE - 20'd1;
      1: return BASE + 20'd16;
      2: return 20'($urandom_range(0, 32'h000F_EFFF));
      default: return 20'hFFFFF;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_valid = 1'b0;
    cur_pc = 10'd0; cur_halt = 1'b0;
    bus_if.bus_addr = 20'h00000; bus_if.read = 1'b0; bus_if.write = 1'b0;
    bus_if.pc = 10'd0; bus_if.halted = 1'b0; reset = 1'b1;
    drv_en = 1'b0; drv_val = 16'h0000;
    @(negedge clk);

    // Reset values.
    cyc(20'h00000, 1'b0, 1'b0, 16'h0000, 10'd0, 1'b0, 1'b1);
    cyc(20'h00000, 1'b0, 1'b0, 16'h0000, 10'd0, 1'b0, 1'b1);
    rdc(4'd0, 16'h0000, "reset_cyc_lo");
    rdc(4'd8, 16'h0001, "reset_ctrl");
    rdc(4'd9, 16'h0000, "reset_status");

    // 100 cycles, pc changing every 2 cycles, then halt.
    cyc(20'h00000, 1'b0, 1'b0, 16'h0000, 10'd0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cur_pc = 10'(i / 2);
      idle(1);
    end
    cur_halt = 1'b1;
    idle(1);
    rdc(4'd0, 16'd100, "halt_cyc");
    rdc(4'd2, 16'd50, "halt_ins");
    rdc(4'd4, 16'd0, "halt_rd");
    rdc(4'd6, 16'd0, "halt_wr");
    rdc(4'd8, 16'h0005, "halt_ctrl");
    for (int i = 0; i < 20; i++) begin
      cur_pc = cur_pc + 10'd1;
      idle(1);
    end
    rdc(4'd0, 16'd100, "frozen_cyc");
    rdc(4'd2, 16'd50, "frozen_ins");
    rdc(4'd1, 16'd0, "frozen_cyc_hi");

    // Outside reads/writes counted, self reads not.
    cur_halt = 1'b0;
    wrc(4'd8, 16'h0003);
    for (int i = 0; i < 7; i++) cyc(20'h00010, 1'b1, 1'b0, 16'h0000, cur_pc, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(20'h00010, 1'b0, 1'b1, 16'($urandom), cur_pc, 1'b0, 1'b0);
    rdc(4'd0, 16'd10, "self_rd0");
    rdc(4'd0, 16'd11, "self_rd1");
    rdc(4'd4, 16'd7, "rd_count");
    rdc(4'd6, 16'd3, "wr_count");
    rdc(4'd3, 16'd0, "ins_hi");

    // Saturation from a preset just below max.
    wrc(4'd8, 16'h0000);
    force u_dut.g_cnt[0].u_cnt.cnt_q = 32'hFFFF_FFFE;
    idle(1);
    release u_dut.g_cnt[0].u_cnt.cnt_q;
    m_cnt[0] = 64'h0000_0000_FFFF_FFFE;
    wrc(4'd8, 16'h0001);
    idle(1);
    check("ovf_before", {15'd0, overflow}, 16'h0000);
    idle(1);
    check("ovf_after_sat", {15'd0, overflow}, 16'h0001);
    idle(1);
    rdc(4'd0, 16'hFFFF, "sat_lo");
    rdc(4'd1, 16'hFFFF, "sat_hi");
    rdc(4'd9, 16'h0001, "sat_status");
    // Clear beats a same-cycle saturating increment.
    wrc(4'd8, 16'h0003);
    rdc(4'd0, 16'h0000, "clr_cyc_lo");
    rdc(4'd1, 16'h0000, "clr_cyc_hi");
    rdc(4'd9, 16'h0000, "clr_status");
    rdc(4'd2, 16'h0001, "first_ins");

    // W1C on a held overflow flag.
    wrc(4'd8, 16'h0000);
    force u_dut.g_cnt[0].u_cnt.cnt_q = 32'hFFFF_FFFF;
    idle(1);
    release u_dut.g_cnt[0].u_cnt.cnt_q;
    m_cnt[0] = 64'h0000_0000_FFFF_FFFF;
    wrc(4'd8, 16'h0001);
    idle(1);
    wrc(4'd8, 16'h0000);
    check("ovf_set", {15'd0, overflow}, 16'h0001);
    wrc(4'd9, 16'h0001);
    check("ovf_w1c", {15'd0, overflow}, 16'h0000);
    rdc(4'd9, 16'h0000, "status_w1c");

    // Lo/hi coherence across a carry into the hi word.
    force u_dut.g_cnt[0].u_cnt.cnt_q = 32'h0000_FFFF;
    idle(1);
    release u_dut.g_cnt[0].u_cnt.cnt_q;
    m_cnt[0] = 64'h0000_0000_0000_FFFF;
    wrc(4'd8, 16'h0001);
    rdc(4'd0, 16'hFFFF, "snap_lo");
    idle(1);
    rdc(4'd1, SNAP ? 16'h0000 : 16'h0001, "snap_hi");

    // Disabled window excluded from CYC; outside reads leave bus_data floating.
    wrc(4'd8, 16'h0003);
    wrc(4'd8, 16'h0000);
    for (int i = 0; i < 10; i++) cyc(rand_outside(), 1'b1, 1'b0, 16'h0000, cur_pc, 1'b0, 1'b0);
    wrc(4'd8, 16'h0001);
    rdc(4'd0, 16'd1, "en_gap_cyc");
    rdc(4'd4, 16'd0, "en_gap_rd");
    rdc(4'd10, 16'd0, "unmapped");

    // Random traffic checked by the model on every cycle.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [15:0] d;
      if ($urandom_range(0, 1) == 0) cur_pc = 10'($urandom);
      cur_halt = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      case (r)
        3: cyc(rand_outside(), 1'b1, 1'b0, 16'h0000, cur_pc, cur_halt, 1'b0);
        4: cyc(rand_outside(), 1'b0, 1'b1, d, cur_pc, cur_halt, 1'b0);
        5, 6: cyc(BASE + 20'($urandom_range(0, 15)), 1'b1, 1'b0, 16'h0000, cur_pc, cur_halt, 1'b0);
        7: begin
          d[0] = ($urandom_range(0, 3) != 0);
          d[1] = ($urandom_range(0, 7) == 0);
          cyc(BASE + 20'd8, 1'b0, 1'b1, d, cur_pc, cur_halt, 1'b0);
        end
        8: cyc(BASE + 20'd9, 1'b0, 1'b1, d, cur_pc, cur_halt, 1'b0);
        9: cyc(BASE + 20'($urandom_range(0, 1) == 0 ? $urandom_range(0, 7) : $urandom_range(10, 15)),
               1'b0, 1'b1, d, cur_pc, cur_halt, 1'b0);
        default: idle(1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
